echo_request_deserializer: RTL and testbench

//  Rebuilds one packed echo request from a 32-bit word stream and presents it on the pipe$enq

---
 rtl/echo_request_deserializer.sv | 146 ++++++++++++++
 tb/tb_echo_request_deserializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_deserializer.sv
// echo_request_deserializer
//   Collects one echo request from a 32-bit word stream and presents it as a single packed
//   message to the request decoder. The first word is a header: tag in [15:0], payload length
//   in words in [31:16]. Output word 0 is {16'b0, tag}, payload word i lands in output word i+1,
//   and output words the message does not write are zero. The block holds one message at a time
//   and stalls the word stream until that message is taken. A message whose payload does not fit
//   is consumed and thrown away, and a saturating counter records how many were dropped.
//
// Ports
//   CLK             clock
//   RST             synchronous active-high reset
//   in_enq_ena_i    stream word valid
//   in_enq_v_i      stream word
//   in_enq_rdy_o    word is taken when ena && rdy
//   pipe_enq_ena_o  assembled message valid
//   pipe_enq_v_o    assembled message, 32*NWORDS bits
//   pipe_enq_rdy_i  downstream takes the message when ena && rdy
//   drop_count      saturating count of dropped oversize messages
module echo_request_deserializer #(
  parameter int unsigned NWORDS = 6,
  parameter int unsigned CNTW   = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_enq_ena_i,
  input  logic [31:0]            in_enq_v_i,
  output logic                   in_enq_rdy_o,
  output logic                   pipe_enq_ena_o,
  output logic [32*NWORDS-1:0]   pipe_enq_v_o,
  input  logic                   pipe_enq_rdy_i,
  output logic [CNTW-1:0]        drop_count
);

  localparam int unsigned MsgW = 32 * NWORDS;
  localparam int unsigned IdxW = $clog2(NWORDS + 1);
  // Largest payload that still fits next to the tag word.
  localparam logic [15:0] MaxLen = 16'(NWORDS - 1);

  typedef enum logic [1:0] {
    StHdr,
    StBody,
    StSend,
    StDrain
  } state_e;

  state_e              state_q, state_d;
  logic [MsgW-1:0]     buf_q, buf_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [15:0]         rem_q, rem_d;
  logic [CNTW-1:0]     drop_q, drop_d;

  logic                word_acc;
  logic [15:0]         hdr_len;
  logic [15:0]         hdr_tag;

  assign hdr_len  = in_enq_v_i[31:16];
  assign hdr_tag  = in_enq_v_i[15:0];
  assign word_acc = in_enq_ena_i && (state_q != StSend);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    drop_d  = drop_q;

    unique case (state_q)
      StHdr: begin
        if (word_acc) begin
          if (hdr_len == 16'd0) begin
            buf_d        = '0;
            buf_d[15:0]  = hdr_tag;
            state_d      = StSend;
          end else if (hdr_len <= MaxLen) begin
            buf_d        = '0;
            buf_d[15:0]  = hdr_tag;
            idx_d        = IdxW'(1);
            rem_d        = hdr_len;
            state_d      = StBody;
          end else begin
            // Oversize: buffer untouched, just count the payload words away.
            rem_d        = hdr_len;
            state_d      = StDrain;
          end
        end
      end

      StBody: begin
        if (word_acc) begin
          for (int unsigned i = 1; i < NWORDS; i++) begin
            if (idx_q == IdxW'(i)) begin
              buf_d[32*i +: 32] = in_enq_v_i;
            end
          end
          idx_d = idx_q + IdxW'(1);
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = StSend;
          end
        end
      end

      StDrain: begin
        if (word_acc) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = StHdr;
            if (drop_q != {CNTW{1'b1}}) begin
              drop_d = drop_q + CNTW'(1);
            end
          end
        end
      end

      StSend: begin
        if (pipe_enq_rdy_i) begin
          state_d = StHdr;
        end
      end

      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StHdr;
      buf_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

  assign in_enq_rdy_o   = (state_q != StSend);
  assign pipe_enq_ena_o = (state_q == StSend);
  assign pipe_enq_v_o   = buf_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_echo_request_deserializer.sv
// Self-checking bench for echo_request_deserializer: directed latency, stall, oversize-drop and
// reset cases, then 1000 random messages with gaps and downstream stalls. Expected messages are
// queued when their words are driven and popped when the block hands a message over.
module tb_echo_request_deserializer;

  localparam int unsigned NWORDS = 6;
  localparam int unsigned CNTW   = 16;
  localparam int unsigned W      = 32 * NWORDS;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            in_ena   = 1'b0;
  logic [31:0]     in_v     = '0;
  logic            in_rdy;
  logic            pipe_ena;
  logic [W-1:0]    pipe_v;
  logic            pipe_rdy = 1'b0;
  logic [CNTW-1:0] drop_count;

  int              n_tests   = 0;
  int              n_fail    = 0;
  int              exp_drops = 0;
  int              exp_recv  = 0;
  int              n_recv    = 0;
  bit              prod_done = 1'b0;
  logic [W-1:0]    sb_q[$];
  logic [W-1:0]    mon_exp;
  logic [31:0]     pl[16];

  echo_request_deserializer #(
    .NWORDS(NWORDS),
    .CNTW  (CNTW)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .in_enq_ena_i  (in_ena),
    .in_enq_v_i    (in_v),
    .in_enq_rdy_o  (in_rdy),
    .pipe_enq_ena_o(pipe_ena),
    .pipe_enq_v_o  (pipe_v),
    .pipe_enq_rdy_i(pipe_rdy),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge after the word was taken.
  task automatic put_word(input logic [31:0] w);
    int k;
    k      = 0;
    in_ena = 1'b1;
    in_v   = w;
    while (!in_rdy) begin
      @(negedge clk);
      k++;
      if (k > 500) begin
        check("put_timeout", W'(in_rdy), W'(1));
        in_ena = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_ena = 1'b0;
  endtask

  // Payload comes from pl[]; the expected message is queued before any word is driven.
  task automatic send_msg(input logic [15:0] tag, input logic [15:0] len, input int max_gap);
    logic [W-1:0] e;
    e       = '0;
    e[15:0] = tag;
    if (len <= 16'(NWORDS - 1)) begin
      for (int i = 0; i < int'(len); i++) e[32*(i+1) +: 32] = pl[i];
      sb_q.push_back(e);
      exp_recv++;
    end else begin
      exp_drops++;
    end
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    put_word({len, tag});
    for (int i = 0; i < int'(len); i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      put_word((i < 16) ? pl[i] : $urandom());
    end
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", W'(sb_q.size()), W'(0));
  endtask

  // Scoreboard monitor: sampled just after the negedge, when all inputs are settled.
  always @(negedge clk) begin
    #1;
    if (!rst && pipe_ena && pipe_rdy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_msg", W'(pipe_ena), W'(0));
      end else begin
        mon_exp = sb_q.pop_front();
        check("msg_data", pipe_v, mon_exp);
        n_recv++;
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    int k;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_rdy", W'(in_rdy), W'(1));
    check("rst_pipe_ena", W'(pipe_ena), W'(0));
    check("rst_pipe_v", pipe_v, '0);
    check("rst_drop", W'(drop_count), W'(0));
    rst = 1'b0;
    @(negedge clk);

    // len=2 message: one ENA pulse right after the last word
    pipe_rdy = 1'b1;
    pl[0] = 32'hA;
    pl[1] = 32'hB;
    send_msg(16'd1, 16'd2, 0);
    check("lat_len2", W'(pipe_ena), W'(1));
    @(negedge clk);
    check("pulse_len2", W'(pipe_ena), W'(0));
    check("rdy_after_len2", W'(in_rdy), W'(1));

    // len=0 message
    send_msg(16'd2, 16'd0, 0);
    check("lat_len0", W'(pipe_ena), W'(1));
    @(negedge clk);
    check("pulse_len0", W'(pipe_ena), W'(0));

    // Downstream stall for 5 cycles
    pipe_rdy = 1'b0;
    pl[0] = 32'h1111_0001;
    pl[1] = 32'h2222_0002;
    pl[2] = 32'h3333_0003;
    send_msg(16'h0007, 16'd3, 0);
    held = '0;
    held[15:0]   = 16'h0007;
    held[63:32]  = 32'h1111_0001;
    held[95:64]  = 32'h2222_0002;
    held[127:96] = 32'h3333_0003;
    for (int c = 0; c < 5; c++) begin
      check("stall_ena", W'(pipe_ena), W'(1));
      check("stall_v", pipe_v, held);
      check("stall_in_rdy", W'(in_rdy), W'(0));
      @(negedge clk);
    end
    pipe_rdy = 1'b1;
    @(negedge clk);
    check("post_stall_in_rdy", W'(in_rdy), W'(1));
    check("post_stall_ena", W'(pipe_ena), W'(0));

    // Oversize message dropped, then a valid one
    for (int i = 0; i < 7; i++) pl[i] = $urandom();
    send_msg(16'd1, 16'd7, 0);
    check("drop_one", W'(drop_count), W'(exp_drops));
    check("drop_no_ena", W'(pipe_ena), W'(0));
    pl[0] = 32'h5;
    send_msg(16'd1, 16'd1, 0);
    check("lat_after_drop", W'(pipe_ena), W'(1));
    wait_empty();

    // Reset mid-message
    put_word({16'd2, 16'd3});
    put_word(32'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_drops = 0;
    check("midrst_ena", W'(pipe_ena), W'(0));
    check("midrst_in_rdy", W'(in_rdy), W'(1));
    check("midrst_drop", W'(drop_count), W'(0));
    @(negedge clk);
    check("midrst_ena2", W'(pipe_ena), W'(0));
    pl[0] = 32'h9;
    send_msg(16'd2, 16'd1, 0);
    check("lat_after_rst", W'(pipe_ena), W'(1));
    wait_empty();

    // Random traffic
    fork
      begin
        for (int m = 0; m < 1000; m++) begin
          logic [15:0] len;
          len = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(6, 9))
                                             : 16'($urandom_range(0, 5));
          for (int i = 0; i < 16; i++) pl[i] = $urandom();
          send_msg(16'($urandom()), len, 2);
        end
        prod_done = 1'b1;
      end
      begin
        k = 0;
        while (!prod_done || sb_q.size() != 0) begin
          @(negedge clk);
          pipe_rdy = ($urandom_range(0, 3) != 0);
          k++;
          if (k > 80000) begin
            check("rand_timeout", W'(sb_q.size()), W'(0));
            break;
          end
        end
      end
    join
    pipe_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rand_recv_count", W'(n_recv), W'(exp_recv));
    check("rand_sb_empty", W'(sb_q.size()), W'(0));
    check("rand_drop_count", W'(drop_count), W'(exp_drops));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
